// File: rtl/decode_regfile_if.sv
// Decode/write-back bus for the Y86-64 register file.
// Master is the pipeline side, slave is the register file.
interface decode_regfile_if #(
  parameter int DATA_W = 64
);
  logic [3:0]        icode;
  logic [3:0]        rA;
  logic [3:0]        rB;
  logic              cnd;
  logic              wb_en;
  logic [3:0]        wb_dstE;
  logic [DATA_W-1:0] wb_valE;
  logic [3:0]        wb_dstM;
  logic [DATA_W-1:0] wb_valM;
  logic [3:0]        srcA;
  logic [3:0]        srcB;
  logic [3:0]        dstE;
  logic [3:0]        dstM;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [DATA_W-1:0] rsp_out;

  modport master (
    output icode, rA, rB, cnd,
    output wb_en, wb_dstE, wb_valE,
    output wb_dstM, wb_valM,
    input  srcA, srcB, dstE, dstM,
    input  valA, valB, rsp_out
  );

  modport slave (
    input  icode, rA, rB, cnd,
    input  wb_en, wb_dstE, wb_valE,
    input  wb_dstM, wb_valM,
    output srcA, srcB, dstE, dstM,
    output valA, valB, rsp_out
  );
endinterface

// File: rtl/decode_regfile.sv
// Y86-64 decode / write-back stage with a clocked register file.
// Dual write ports (M wins over E) and optional same-cycle bypass.
module decode_regfile #(
  parameter int          DATA_W   = 64,
  parameter int          NREGS    = 15,
  parameter bit          BYPASS   = 1'b1,
  parameter logic [63:0] SP_RESET = 64'd256
) (
  input  logic         clk,
  input  logic         rst_n,
  decode_regfile_if.slave bus
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic [3:0]        src_a;
  logic [3:0]        src_b;
  logic [3:0]        dst_e;
  logic [3:0]        dst_m;
  logic [DATA_W-1:0] val_a;
  logic [DATA_W-1:0] val_b;

  // Register IDs from instruction code; unknown codes leave all IDs at none.
  always_comb begin
    src_a = RNONE;
    src_b = RNONE;
    dst_e = RNONE;
    dst_m = RNONE;
    unique case (1'b1)
      (bus.icode == 4'h2): begin
        src_a = bus.rA;
        dst_e = bus.cnd ? bus.rB : RNONE;
      end
      (bus.icode == 4'h3): dst_e = bus.rB;
      (bus.icode == 4'h4): begin
        src_a = bus.rA;
        src_b = bus.rB;
      end
      (bus.icode == 4'h5): begin
        src_b = bus.rB;
        dst_m = bus.rA;
      end
      (bus.icode == 4'h6): begin
        src_a = bus.rA;
        src_b = bus.rB;
        dst_e = bus.rB;
      end
      (bus.icode == 4'h8): begin
        src_b = RSP;
        dst_e = RSP;
      end
      (bus.icode == 4'h9): begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
      end
      (bus.icode == 4'hA): begin
        src_a = bus.rA;
        src_b = RSP;
        dst_e = RSP;
      end
      (bus.icode == 4'hB): begin
        src_a = RSP;
        src_b = RSP;
        dst_e = RSP;
        dst_m = bus.rA;
      end
      default: ;
    endcase
  end

  // Operand read; pending write data overrides storage, M before E.
  always_comb begin
    val_a = '0;
    val_b = '0;
    for (int i = 0; i < NREGS; i++) begin
      if (src_a == 4'(i)) val_a = regs_q[i];
      if (src_b == 4'(i)) val_b = regs_q[i];
    end
    if (BYPASS && bus.wb_en) begin
      if (int'(src_a) < NREGS) begin
        if (src_a == bus.wb_dstM)      val_a = bus.wb_valM;
        else if (src_a == bus.wb_dstE) val_a = bus.wb_valE;
      end
      if (int'(src_b) < NREGS) begin
        if (src_b == bus.wb_dstM)      val_b = bus.wb_valM;
        else if (src_b == bus.wb_dstE) val_b = bus.wb_valE;
      end
    end
  end

  // Next register contents; the M port is applied last so it wins.
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_en) begin
      for (int i = 0; i < NREGS; i++)
        if (bus.wb_dstE == 4'(i)) regs_d[i] = bus.wb_valE;
      for (int i = 0; i < NREGS; i++)
        if (bus.wb_dstM == 4'(i)) regs_d[i] = bus.wb_valM;
    end
  end

  // Register storage; reset clears all and seeds the stack pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++)
        regs_q[i] <= (i == 4) ? DATA_W'(SP_RESET) : '0;
    end else begin
      regs_q <= regs_d;
    end
  end

  assign bus.srcA = src_a;
  assign bus.srcB = src_b;
  assign bus.dstE = dst_e;
  assign bus.dstM = dst_m;
  assign bus.valA = val_a;
  assign bus.valB = val_b;

  if (NREGS > 4) begin : g_rsp
    assign bus.rsp_out = regs_q[4];
  end else begin : g_no_rsp
    assign bus.rsp_out = '0;
  end

endmodule
